// File: rtl/load_store_unit_if.sv
// Avalon-MM style memory port between the load/store unit and its memory slave.
interface load_store_unit_if;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic [31:0] avm_writedata_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_waitrequest_i;
  logic [31:0] avm_readdata_i;

  modport master (
    output avm_address_o,
    output avm_read_o,
    output avm_write_o,
    output avm_writedata_o,
    output avm_byteenable_o,
    input  avm_waitrequest_i,
    input  avm_readdata_i
  );

  modport slave (
    input  avm_address_o,
    input  avm_read_o,
    input  avm_write_o,
    input  avm_writedata_o,
    input  avm_byteenable_o,
    output avm_waitrequest_i,
    output avm_readdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per memory instruction, with byte-lane
// steering, load extraction/extension, misalignment and stall-timeout reporting.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [5:0]              opcode_i,
  input  logic [31:0]             effective_address_i,
  input  logic [31:0]             rt_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             load_data_o,
  output logic                    addr_error_o,
  output logic                    bus_error_o,
  load_store_unit_if.master       avm
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam bit          LIMITED  = (WAIT_LIMIT != 0);
  localparam logic [31:0] LIMIT_M1 = 32'(WAIT_LIMIT - 1);

  state_t      state;
  size_t       lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [31:0] wait_cnt;

  logic        dec_valid;
  logic        dec_store;
  logic        dec_signed;
  size_t       dec_size;
  logic        dec_aligned;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // Decode the launch request: operation class, alignment, lanes and store data.
  always_comb begin
    dec_valid   = 1'b1;
    dec_store   = 1'b0;
    dec_signed  = 1'b0;
    dec_size    = SZ_W;
    dec_aligned = 1'b1;
    dec_be      = 4'b1111;
    dec_wdata   = rt_i;
    case (opcode_i)
      6'h20: begin dec_size = SZ_B; dec_signed = 1'b1; end
      6'h21: begin dec_size = SZ_H; dec_signed = 1'b1; end
      6'h23: dec_size = SZ_W;
      6'h24: dec_size = SZ_B;
      6'h25: dec_size = SZ_H;
      6'h28: begin dec_size = SZ_B; dec_store = 1'b1; end
      6'h29: begin dec_size = SZ_H; dec_store = 1'b1; end
      6'h2B: begin dec_size = SZ_W; dec_store = 1'b1; end
      default: dec_valid = 1'b0;
    endcase
    case (dec_size)
      SZ_B: begin
        dec_aligned = 1'b1;
        dec_be      = 4'b0001 << effective_address_i[1:0];
        dec_wdata   = {24'b0, rt_i[7:0]} << {effective_address_i[1:0], 3'b000};
      end
      SZ_H: begin
        dec_aligned = ~effective_address_i[0];
        dec_be      = effective_address_i[1] ? 4'b1100 : 4'b0011;
        dec_wdata   = effective_address_i[1] ? {rt_i[15:0], 16'b0} : {16'b0, rt_i[15:0]};
      end
      default: begin
        dec_aligned = (effective_address_i[1:0] == 2'b00);
        dec_be      = 4'b1111;
        dec_wdata   = rt_i;
      end
    endcase
  end

  // Extract and extend the load value from the live read data using the latched request.
  always_comb begin
    rd_shifted = avm.avm_readdata_i >> {lat_off, 3'b000};
    case (lat_size)
      SZ_B:    load_ext = {{24{lat_signed & rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_H:    load_ext = {{16{lat_signed & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = avm.avm_readdata_i;
    endcase
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state                <= IDLE;
      lat_size             <= SZ_W;
      lat_signed           <= 1'b0;
      lat_off              <= '0;
      wait_cnt             <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      load_data_o          <= '0;
      addr_error_o         <= 1'b0;
      bus_error_o          <= 1'b0;
      avm.avm_address_o    <= '0;
      avm.avm_read_o       <= 1'b0;
      avm.avm_write_o      <= 1'b0;
      avm.avm_writedata_o  <= '0;
      avm.avm_byteenable_o <= '0;
    end else begin
      done_o       <= 1'b0;
      addr_error_o <= 1'b0;
      bus_error_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && dec_valid) begin
            busy_o <= 1'b1;
            if (!dec_aligned) begin
              state        <= DONE;
              done_o       <= 1'b1;
              addr_error_o <= 1'b1;
            end else begin
              state                <= ACCESS;
              wait_cnt             <= '0;
              lat_size             <= dec_size;
              lat_signed           <= dec_signed;
              lat_off              <= effective_address_i[1:0];
              avm.avm_address_o    <= {effective_address_i[31:2], 2'b00};
              avm.avm_read_o       <= ~dec_store;
              avm.avm_write_o      <= dec_store;
              avm.avm_writedata_o  <= dec_store ? dec_wdata : '0;
              avm.avm_byteenable_o <= dec_be;
            end
          end
        end
        ACCESS: begin
          if (!avm.avm_waitrequest_i) begin
            avm.avm_read_o  <= 1'b0;
            avm.avm_write_o <= 1'b0;
            if (avm.avm_read_o) load_data_o <= load_ext;
            done_o <= 1'b1;
            state  <= DONE;
          end else if (LIMITED && wait_cnt == LIMIT_M1) begin
            avm.avm_read_o  <= 1'b0;
            avm.avm_write_o <= 1'b0;
            done_o          <= 1'b1;
            bus_error_o     <= 1'b1;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses checked
// against an arithmetic reference model of lanes, store data and load extension.
module tb_load_store_unit;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  logic [5:0]  opcode_i;
  logic [31:0] effective_address_i;
  logic [31:0] rt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        addr_error_o;
  logic        bus_error_o;

  load_store_unit_if bus ();

  load_store_unit #(.WAIT_LIMIT(4)) dut (
    .clk                 (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .rt_i                (rt_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .load_data_o         (load_data_o),
    .addr_error_o        (addr_error_o),
    .bus_error_o         (bus_error_o),
    .avm                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_ld = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte count, lane start, enables, store data and extended load value.
  task automatic model(input logic [5:0] op, input logic [31:0] a, rt, rd,
                       output bit valid, output bit st, output bit misal,
                       output logic [31:0] ebe, output logic [31:0] ewd,
                       output logic [31:0] eld);
    int unsigned nb;
    int unsigned lane;
    bit sg;
    longint unsigned mask;
    longint v;
    valid = 1; st = 0; sg = 0; nb = 4;
    case (op)
      6'h20: begin nb = 1; sg = 1; end
      6'h21: begin nb = 2; sg = 1; end
      6'h23: nb = 4;
      6'h24: nb = 1;
      6'h25: nb = 2;
      6'h28: begin nb = 1; st = 1; end
      6'h29: begin nb = 2; st = 1; end
      6'h2B: begin nb = 4; st = 1; end
      default: valid = 0;
    endcase
    lane  = a % 4;
    misal = (a % nb) != 0;
    mask  = (64'd1 << (8 * nb)) - 1;
    ebe   = 32'(((1 << nb) - 1) << lane);
    ewd   = 32'((longint'(rt) & mask) << (8 * lane));
    v     = longint'((longint'(rd) >> (8 * lane)) & mask);
    if (sg && v > longint'(mask >> 1)) v = v - longint'(mask + 1);
    eld   = v[31:0];
  endtask

  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a, rt, rd,
                        input int unsigned nwait);
    bit valid, st, misal;
    logic [31:0] ebe, ewd, eld;
    model(op, a, rt, rd, valid, st, misal, ebe, ewd, eld);
    @(negedge clk);
    start_i = 1'b1; opcode_i = op; effective_address_i = a; rt_i = rt;
    @(negedge clk);
    start_i = 1'b0; opcode_i = 6'($urandom); effective_address_i = $urandom; rt_i = $urandom;
    if (!valid) begin
      chk({tag, " ignored busy"}, 32'(busy_o), 0);
      chk({tag, " ignored bus"}, 32'(bus.avm_read_o | bus.avm_write_o), 0);
      return;
    end
    if (misal) begin
      chk({tag, " misal done"}, 32'(done_o), 1);
      chk({tag, " misal addr_error"}, 32'(addr_error_o), 1);
      chk({tag, " misal no bus"}, 32'(bus.avm_read_o | bus.avm_write_o), 0);
      chk({tag, " misal load hold"}, load_data_o, exp_ld);
      @(negedge clk);
      chk({tag, " misal post done"}, 32'({done_o, addr_error_o, busy_o}), 0);
      return;
    end
    for (int unsigned k = 0; k <= nwait; k++) begin
      chk({tag, " read"}, 32'(bus.avm_read_o), 32'(!st));
      chk({tag, " write"}, 32'(bus.avm_write_o), 32'(st));
      chk({tag, " address"}, bus.avm_address_o, a & ~32'd3);
      chk({tag, " byteenable"}, 32'(bus.avm_byteenable_o), ebe);
      if (st) chk({tag, " writedata"}, bus.avm_writedata_o, ewd);
      chk({tag, " busy/done in access"}, 32'({busy_o, done_o}), 32'b10);
      bus.avm_waitrequest_i = (k < nwait);
      bus.avm_readdata_i    = (k < nwait) ? $urandom : rd;
      @(negedge clk);
    end
    bus.avm_waitrequest_i = 1'b0;
    if (!st) exp_ld = eld;
    chk({tag, " done"}, 32'({done_o, busy_o}), 32'b11);
    chk({tag, " errors"}, 32'({addr_error_o, bus_error_o}), 0);
    chk({tag, " bus idle at done"}, 32'(bus.avm_read_o | bus.avm_write_o), 0);
    chk({tag, " load_data"}, load_data_o, exp_ld);
    @(negedge clk);
    chk({tag, " post done"}, 32'({done_o, busy_o}), 0);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  initial begin
    reset_i = 1'b1; start_i = 1'b0; opcode_i = '0; effective_address_i = '0; rt_i = '0;
    bus.avm_waitrequest_i = 1'b0; bus.avm_readdata_i = '0;
    repeat (3) @(negedge clk);
    chk("reset status", 32'({busy_o, done_o, addr_error_o, bus_error_o}), 0);
    chk("reset load_data", load_data_o, 0);
    chk("reset bus ctl", 32'({bus.avm_read_o, bus.avm_write_o, bus.avm_byteenable_o}), 0);
    chk("reset address", bus.avm_address_o, 0);
    chk("reset writedata", bus.avm_writedata_o, 0);
    reset_i = 1'b0;

    // 1: word store, zero wait
    run_op("t1 sw", 6'h2B, 32'h1004, 32'hDEADBEEF, 32'h0, 0);
    // 2: signed then unsigned byte load, top lane
    run_op("t2 lb", 6'h20, 32'h2003, 32'h0, 32'h80112233, 0);
    chk("t2 lb value", load_data_o, 32'hFFFFFF80);
    run_op("t2 lbu", 6'h24, 32'h2003, 32'h0, 32'h80112233, 0);
    chk("t2 lbu value", load_data_o, 32'h00000080);
    // 3: upper halfword store / unsigned load
    run_op("t3 sh", 6'h29, 32'h3002, 32'h0000ABCD, 32'h0, 0);
    run_op("t3 lhu", 6'h25, 32'h3002, 32'h0, 32'hABCD1234, 0);
    chk("t3 lhu value", load_data_o, 32'h0000ABCD);
    // 4: word load with three stall cycles
    run_op("t4 lw", 6'h23, 32'h4000, 32'h0, 32'h12345678, 3);
    chk("t4 lw value", load_data_o, 32'h12345678);
    // 5: misaligned accesses, then a byte load at an odd address
    run_op("t5 lw misal", 6'h23, 32'h1001, 32'h0, 32'h0, 0);
    run_op("t5 lh misal", 6'h21, 32'h1003, 32'h0, 32'h0, 0);
    run_op("t5 lb odd", 6'h20, 32'h1003, 32'h0, 32'h7F000000, 1);
    chk("t5 lb value", load_data_o, 32'h0000007F);
    // non-memory opcode
    run_op("nonmem", 6'h22, 32'h5000, 32'h0, 32'h0, 0);

    // 6a: waitrequest stuck high, abort after four stall cycles
    @(negedge clk);
    start_i = 1'b1; opcode_i = 6'h23; effective_address_i = 32'h6000;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6 stalled read", 32'({bus.avm_read_o, done_o}), 32'b10);
      bus.avm_waitrequest_i = 1'b1;
      bus.avm_readdata_i    = $urandom;
      @(negedge clk);
    end
    chk("t6 abort done/bus_error", 32'({done_o, bus_error_o, addr_error_o}), 32'b110);
    chk("t6 abort read dropped", 32'(bus.avm_read_o), 0);
    chk("t6 abort load hold", load_data_o, exp_ld);
    @(negedge clk);
    chk("t6 abort one cycle", 32'({done_o, bus_error_o, busy_o}), 0);

    // 6b: reset during a stall
    @(negedge clk);
    start_i = 1'b1; opcode_i = 6'h23; effective_address_i = 32'h7000;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("t6 pre-reset read", 32'(bus.avm_read_o), 1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    exp_ld = '0;
    chk("t6 reset read drop", 32'({bus.avm_read_o, done_o, busy_o}), 0);
    @(negedge clk);
    chk("t6 reset no done", 32'({done_o, busy_o}), 0);
    bus.avm_waitrequest_i = 1'b0;
    run_op("t6 after reset", 6'h21, 32'h7002, 32'h0, 32'h8001FFFF, 0);

    // randomized accesses, stalls below the abort limit
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op("rand", ops[$urandom_range(0, 7)], a, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU; consumes the effective address and rt store value for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Runs one Avalon-MM style transaction per instruction: word-aligned address, byte enables, lane-shifted write data, waitrequest stall.
- Returns the extracted, sign- or zero-extended load value to writeback and flags misaligned accesses.
- Memory is little-endian: byte offset 0 maps to bits [7:0].

Parameters:
- WAIT_LIMIT, 0, max cycles a request is held under waitrequest before abort; 0 = unlimited.

Ports:
- clk  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  launch access; sampled only in IDLE
- opcode_i  in  6  opcode: LB=0x20 LH=0x21 LW=0x23 LBU=0x24 LHU=0x25 SB=0x28 SH=0x29 SW=0x2B
- effective_address_i  in  32  byte address from the ALU
- rt_i  in  32  store data from the ALU
- busy_o  out  1  access in progress
- done_o  out  1  one-cycle completion pulse
- load_data_o  out  32  extended load result; valid from the done pulse
- addr_error_o  out  1  pulses with done_o on a misaligned access
- bus_error_o  out  1  pulses with done_o on a WAIT_LIMIT abort
- avm_address_o  out  32  word address, effective_address with [1:0] = 0
- avm_read_o  out  1  read request
- avm_write_o  out  1  write request
- avm_writedata_o  out  32  lane-aligned store data
- avm_byteenable_o  out  4  active byte lanes
- avm_waitrequest_i  in  1  slave stall
- avm_readdata_i  in  32  read data; valid in the cycle read is high and waitrequest is low

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. The FSM goes to IDLE and the wait counter clears.
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS: on start_i with a valid memory opcode and an aligned address. The request is latched at edge N, and bus signals assert from cycle N+1.
- Alignment rule:
  - Halfword ops require a[0] = 0.
  - Word ops require a[1:0] = 0.
  - Byte ops are always aligned.
- IDLE -> DONE: on start_i with a misaligned address. There is no bus activity. done_o and addr_error_o are high in cycle N+1, and load_data_o is unchanged.
- start_i with a non-memory opcode is ignored; the FSM stays in IDLE.
- ACCESS:
  - Exactly one of avm_read_o/avm_write_o is high.
  - Address, writedata and byteenable are held stable while avm_waitrequest_i = 1.
  - The transaction completes on the first edge where waitrequest = 0. Read/write drop at that edge, and the FSM goes to DONE.
  - With a zero-wait slave, done_o is high in cycle N+2.
  - Each stall cycle adds one cycle of latency.
- WAIT_LIMIT > 0:
  - Count ACCESS cycles with waitrequest high.
  - When the count reaches WAIT_LIMIT, drop the request and go to DONE with bus_error_o = 1.
  - load_data_o is unchanged.
- DONE: done_o = 1 for exactly one cycle, then IDLE. A start_i in the DONE cycle is ignored.
- busy_o = 1 in ACCESS and DONE; 0 in IDLE.
- Byte enables, with b = a[1:0]:
  - Byte ops: 1 << b.
  - Halfword ops: 0011 if a[1] = 0, 1100 if a[1] = 1.
  - Word ops: 1111.
- Write data:
  - SB: rt[7:0] << 8*b.
  - SH: rt[15:0] << 16*a[1].
  - SW: rt.
  - Unused lanes are 0.
- Load extract:
  - LB/LBU: byte = readdata >> 8*b.
  - LH/LHU: half = readdata >> 16*a[1].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend. LW passes readdata through.
  - readdata is captured at the completing edge.
- load_data_o:
  - Updates only on successful loads.
  - Stores and errors leave it unchanged.
  - It holds until the next successful load.
- Reset mid-ACCESS: read/write drop at that edge, no done_o is produced, and the FSM returns to IDLE.
- Inputs are only sampled at launch. Changes to opcode/address/rt during an access have no effect.

Test Plan:
1. SW rt=0xDEADBEEF, addr=0x1004, zero-wait -> cycle N+1: address 0x1004, write=1, byteenable=1111, writedata=0xDEADBEEF. Cycle N+2: done=1, errors=0.
2. LB addr=0x2003, readdata=0x80112233; then LBU at the same address -> first load_data_o = 0xFFFFFF80, second = 0x00000080. Bus address 0x2000, byteenable=1000.
3. SH rt=0x0000ABCD, addr=0x3002 -> byteenable=1100, writedata=0xABCD0000. LHU at the same address with readdata 0xABCD1234 -> 0x0000ABCD.
4. LW with waitrequest held 3 cycles, readdata=0x12345678 -> read and address stable for 4 cycles, done exactly 1 cycle later, load_data_o = 0x12345678, busy high throughout.
5. LW addr=0x1001 and LH addr=0x1003 -> no read/write asserted, done=1 and addr_error=1 at N+1, load_data_o unchanged. LB addr=0x1003 still runs.
6. WAIT_LIMIT=4 with waitrequest stuck at 1 -> request dropped after 4 stall cycles, done=bus_error=1 for one cycle. Separately, reset mid-stall -> read drops next edge, no done pulse, and a new start then works.
